// File: rtl/lsu_hs.sv
// lsu_hs: load/store unit with a valid/ready request/response handshake.
//
// Sits between the core memory stage and an internal byte-lane data RAM
// organised as DATA_WIDTH/8 little-endian lanes. One transaction at a time:
// IDLE accepts a request, ACCESS performs the store or captures the load,
// and RESP holds the response until the consumer takes it.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   addr_in, data_in      byte address, right-aligned store data
//   WE_in, dtypes_in      1 = store / 0 = load, access type encoding
//   resp_valid/resp_ready response handshake
//   data_out, resp_err    extended load data (0 for stores/errors), error flag
//
// Optional build macro LSU_PERF_CNT_EN adds saturating 16-bit ld_count,
// st_count and err_count outputs.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | request latched; memory access or error decision on next edge
// RESP   | response presented, waiting for resp_ready

module lsu_hs #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_SPACE  = 4096,
  parameter int NUM_DATA_TYPES = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [$clog2(ADDRESS_SPACE)-1:0]  addr_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              WE_in,
  input  logic [$clog2(NUM_DATA_TYPES)-1:0] dtypes_in,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              resp_err
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]                       ld_count,
  output logic [15:0]                       st_count,
  output logic [15:0]                       err_count
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LW    = $clog2(NB);
  localparam int AW    = $clog2(ADDRESS_SPACE);
  localparam int TW    = $clog2(NUM_DATA_TYPES);
  localparam int DEPTH = ADDRESS_SPACE / NB;
  localparam bit WIDE  = (DATA_WIDTH == 64);

  localparam logic [TW-1:0] T_BYTE   = TW'(0);
  localparam logic [TW-1:0] T_HALF   = TW'(1);
  localparam logic [TW-1:0] T_WORD   = TW'(2);
  localparam logic [TW-1:0] T_BYTE_U = TW'(3);
  localparam logic [TW-1:0] T_HALF_U = TW'(4);
  localparam logic [TW-1:0] T_WORD_U = TW'(5);
  localparam logic [TW-1:0] T_DOUBLE = TW'(6);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  we_q;
  logic [TW-1:0]         dtype_q;

  // Memory contents survive reset, so the array has no reset branch.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]         lane;
  logic [AW-LW-1:0]      word_idx;
  logic [LW+2:0]         bit_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [7:0]            size_mask;
  logic [NB-1:0]         byte_en;
  logic                  req_err;
  logic                  do_write;

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = S_ACCESS;
      end
      S_ACCESS: next_state = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Request capture; inputs only need to be valid at the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      dtype_q <= '0;
    end else if (state == S_IDLE && req_valid) begin
      addr_q  <= addr_in;
      data_q  <= data_in;
      we_q    <= WE_in;
      dtype_q <= dtypes_in;
    end
  end

  assign lane     = addr_q[LW-1:0];
  assign word_idx = addr_q[AW-1:LW];
  assign bit_sh   = {lane, 3'b000};
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> bit_sh;

  // Type decode: access size, alignment/legality, and load extension.
  always_comb begin
    size_mask = 8'h00;
    req_err   = 1'b0;
    load_ext  = '0;
    case (dtype_q)
      T_BYTE: begin
        size_mask = 8'h01;
        load_ext  = DATA_WIDTH'($signed(rd_shift[7:0]));
      end
      T_BYTE_U: begin
        size_mask = 8'h01;
        load_ext  = DATA_WIDTH'(rd_shift[7:0]);
      end
      T_HALF: begin
        size_mask = 8'h03;
        req_err   = addr_q[0];
        load_ext  = DATA_WIDTH'($signed(rd_shift[15:0]));
      end
      T_HALF_U: begin
        size_mask = 8'h03;
        req_err   = addr_q[0];
        load_ext  = DATA_WIDTH'(rd_shift[15:0]);
      end
      T_WORD: begin
        size_mask = 8'h0F;
        req_err   = |addr_q[1:0];
        // Sign extension only matters on the 64-bit datapath.
        load_ext  = DATA_WIDTH'($signed(rd_shift[31:0]));
      end
      T_WORD_U: begin
        size_mask = 8'h0F;
        req_err   = !WIDE || (|addr_q[1:0]);
        load_ext  = DATA_WIDTH'(rd_shift[31:0]);
      end
      T_DOUBLE: begin
        size_mask = 8'hFF;
        req_err   = !WIDE || (|addr_q[2:0]);
        load_ext  = rd_shift;
      end
      default: req_err = 1'b1;
    endcase
  end

  assign byte_en  = NB'(size_mask) << lane;
  assign wr_data  = data_q << bit_sh;
  // Gating on reset drops a store whose ACCESS edge coincides with reset.
  assign do_write = (state == S_ACCESS) && we_q && !req_err && !reset;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Response registers hold steady through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      resp_err <= 1'b0;
    end else if (state == S_ACCESS) begin
      data_out <= (we_q || req_err) ? '0 : load_ext;
      resp_err <= req_err;
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (state == S_ACCESS) begin
      if (req_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (we_q) begin
        if (st_count != 16'hFFFF) st_count <= st_count + 16'd1;
      end else begin
        if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_hs.sv
module tb_lsu_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] addr_in;
  logic [31:0] data_in;
  logic        WE_in;
  logic [2:0]  dtypes_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] data_out;
  logic        resp_err;
`ifdef LSU_PERF_CNT_EN
  logic [15:0] ld_count, st_count, err_count;
`endif

  int n_pass = 0;
  int n_checks = 0;

  localparam logic [2:0] BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, BYTE_U = 3'd3,
                         HALF_U = 3'd4, WORD_U = 3'd5, DOUBLE = 3'd6, ILL = 3'd7;

  lsu_hs #(.DATA_WIDTH(32), .ADDRESS_SPACE(4096), .NUM_DATA_TYPES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr_in(addr_in), .data_in(data_in), .WE_in(WE_in), .dtypes_in(dtypes_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .data_out(data_out), .resp_err(resp_err)
`ifdef LSU_PERF_CNT_EN
    , .ld_count(ld_count), .st_count(st_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Issues one request (IDLE assumed), returns the response and the number
  // of edges from acceptance (inclusive) to resp_valid. Ends back in IDLE.
  task automatic xact(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input logic [2:0] t, output logic [31:0] rd, output logic re,
                      output int lat, output bit tmo);
    tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; addr_in = a; data_in = d; WE_in = we; dtypes_in = t;
    @(posedge clk); #1;
    req_valid = 1'b0; data_in = 32'h5A5A_5A5A; addr_in = 12'hFFF;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) tmo = 1'b1;
    rd = data_out; re = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; addr_in = '0; data_in = '0; WE_in = 1'b0;
    dtypes_in = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); else n_pass++;
    n_checks++; if (data_out !== 32'h0) $display("FAIL rst_data_out: got %h expected 0", data_out); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b expected 0", resp_err); else n_pass++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic re; int lat; bit tmo;
    xact(12'h000, 32'hABCDEF00, 1'b1, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h0 || re !== 1'b0) $display("FAIL st_word_resp: got data %h err %b tmo %b expected 0/0/0", rd, re, tmo); else n_pass++;
    xact(12'h000, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hABCDEF00) $display("FAIL ld_word: got %h expected abcdef00", rd); else n_pass++;
    n_checks++; if (re !== 1'b0) $display("FAIL ld_word_err: got %b expected 0", re); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL latency: got %0d edges expected 2", lat); else n_pass++;
  endtask

  task automatic test_half();
    logic [31:0] rd; logic re; int lat; bit tmo;
    xact(12'h012, 32'h0000FFFF, 1'b1, HALF, rd, re, lat, tmo);
    xact(12'h012, 32'h0, 1'b0, HALF, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hFFFFFFFF) $display("FAIL ld_half_s: got %h expected ffffffff", rd); else n_pass++;
    xact(12'h012, 32'h0, 1'b0, HALF_U, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h0000FFFF) $display("FAIL ld_half_u: got %h expected 0000ffff", rd); else n_pass++;
    xact(12'h010, 32'h1234ABCD, 1'b1, HALF, rd, re, lat, tmo);
    xact(12'h010, 32'h0, 1'b0, HALF, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hFFFFABCD) $display("FAIL ld_half_lo: got %h expected ffffabcd", rd); else n_pass++;
    xact(12'h010, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hFFFFABCD) $display("FAIL ld_word_halves: got %h expected ffffabcd", rd); else n_pass++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic re; int lat; bit tmo;
    xact(12'h018, 32'h11223344, 1'b1, WORD, rd, re, lat, tmo);
    xact(12'h01C, 32'h55667788, 1'b1, WORD, rd, re, lat, tmo);
    xact(12'h01B, 32'hFFFFFFCB, 1'b1, BYTE, rd, re, lat, tmo);
    xact(12'h01B, 32'h0, 1'b0, BYTE, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hFFFFFFCB) $display("FAIL ld_byte_s: got %h expected ffffffcb", rd); else n_pass++;
    xact(12'h01B, 32'h0, 1'b0, BYTE_U, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h000000CB) $display("FAIL ld_byte_u: got %h expected 000000cb", rd); else n_pass++;
    xact(12'h01A, 32'h0, 1'b0, BYTE_U, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h00000022) $display("FAIL nbr_01a: got %h expected 00000022", rd); else n_pass++;
    xact(12'h01C, 32'h0, 1'b0, BYTE_U, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h00000088) $display("FAIL nbr_01c: got %h expected 00000088", rd); else n_pass++;
    xact(12'h018, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hCB223344) $display("FAIL word_018: got %h expected cb223344", rd); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic re; int lat; bit tmo;
    xact(12'h002, 32'h12345678, 1'b1, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1 || rd !== 32'h0) $display("FAIL st_misalign: got err %b data %h expected 1/0", re, rd); else n_pass++;
    xact(12'h000, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hABCDEF00 || re !== 1'b0) $display("FAIL after_misalign: got %h err %b expected abcdef00/0", rd, re); else n_pass++;
    xact(12'h000, 32'h0, 1'b0, ILL, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1 || rd !== 32'h0) $display("FAIL illegal_type: got err %b data %h expected 1/0", re, rd); else n_pass++;
    xact(12'h011, 32'h0, 1'b0, HALF_U, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1 || rd !== 32'h0) $display("FAIL half_misalign: got err %b data %h expected 1/0", re, rd); else n_pass++;
    xact(12'h013, 32'h00000000, 1'b1, HALF, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1) $display("FAIL st_half_misalign: got err %b expected 1", re); else n_pass++;
    xact(12'h010, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'hFFFFABCD) $display("FAIL after_half_err: got %h expected ffffabcd", rd); else n_pass++;
    xact(12'h000, 32'h0, 1'b0, WORD_U, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1) $display("FAIL word_u_32: got err %b expected 1", re); else n_pass++;
    xact(12'h000, 32'h0, 1'b0, DOUBLE, rd, re, lat, tmo);
    n_checks++; if (tmo || re !== 1'b1) $display("FAIL double_32: got err %b expected 1", re); else n_pass++;
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd; logic re; int lat; bit tmo;
    xact(12'h004, 32'h00000010, 1'b1, WORD, rd, re, lat, tmo);
    @(negedge clk);
    req_valid = 1'b1; addr_in = 12'h004; data_in = 32'hDEADBEEF; WE_in = 1'b1; dtypes_in = WORD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rst_in_access: got ready %b valid %b expected 1/0", req_ready, resp_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_no_resp: got %b expected 0", resp_valid); else n_pass++;
    xact(12'h004, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h00000010) $display("FAIL rst_store_dropped: got %h expected 00000010", rd); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic re; int lat; bit tmo;
    int bad;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; addr_in = 12'h000; WE_in = 1'b0; dtypes_in = WORD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (!resp_valid || data_out !== 32'hABCDEF00) $display("FAIL bp_first: got valid %b data %h expected 1/abcdef00", resp_valid, data_out); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; addr_in = 12'h004; data_in = 32'hFFFFFFFF; WE_in = 1'b1; dtypes_in = WORD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (resp_valid !== 1'b1 || data_out !== 32'hABCDEF00 || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else n_pass++;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: got valid %b ready %b expected 0/1", resp_valid, req_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_no_ghost: got %b expected 0", resp_valid); else n_pass++;
    xact(12'h004, 32'h0, 1'b0, WORD, rd, re, lat, tmo);
    n_checks++; if (tmo || rd !== 32'h00000010) $display("FAIL bp_ignored_store: got %h expected 00000010", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_half();
    test_byte();
    test_errors();
    test_reset_in_access();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
